// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a clean, debounced button level into one-cycle UI
// event pulses (press, release, click, double-click, long-press, auto-repeat).
// One instance per button, fed by the conditioner, feeding the inference
// control FSM. All outputs are registered, so an edge sampled in cycle N
// produces its pulse in cycle N+1.
//
// The release and repeat pulses are exposed as btn_release and auto_repeat
// because "release" and "repeat" are reserved words in SystemVerilog.

module button_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 25_000_000,
    parameter int unsigned DBL_CYCLES    = 12_500_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000,
    parameter int unsigned CTR_WIDTH     = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic held,
    output logic press,
    output logic btn_release,
    output logic click,
    output logic dbl_click,
    output logic long_press,
    output logic auto_repeat
);

    // State encoding
    localparam logic [2:0] ST_IDLE = 3'd0;  // waiting for first press
    localparam logic [2:0] ST_P1   = 3'd1;  // first press held
    localparam logic [2:0] ST_W2   = 3'd2;  // released, waiting for a second press
    localparam logic [2:0] ST_P2   = 3'd3;  // second press held
    localparam logic [2:0] ST_LONG = 3'd4;  // long hold, auto-repeating

    // Terminal timer values; the timer counts from 0, so a threshold of N
    // cycles is reached when the count equals N-1.
    localparam logic [CTR_WIDTH-1:0] LONG_LAST   = CTR_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] DBL_LAST    = CTR_WIDTH'(DBL_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] REPEAT_LAST = CTR_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] TIMER_MAX   = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] TIMER_ONE   = CTR_WIDTH'(1);

    logic                 prev_q;
    logic [2:0]           state_q, state_d;
    logic [CTR_WIDTH-1:0] timer_q, timer_d;
    logic                 timer_clr;

    logic rise, fall;
    logic click_d, dbl_d, long_d, rpt_d;

    logic held_q, press_q, release_q, click_q, dbl_q, long_q, rpt_q;

    // Edge detection against the previous sampled level
    always_comb begin
        rise = btn_level & ~prev_q;
        fall = ~btn_level & prev_q;
    end

    // Next-state and event decode; edges take priority over timer thresholds
    always_comb begin
        state_d   = state_q;
        timer_clr = 1'b0;
        click_d   = 1'b0;
        dbl_d     = 1'b0;
        long_d    = 1'b0;
        rpt_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_P1;
                end
            end
            ST_P1: begin
                if (fall) begin
                    state_d = ST_W2;
                end else if (timer_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end
            end
            ST_W2: begin
                if (rise) begin
                    state_d = ST_P2;
                end else if (timer_q == DBL_LAST) begin
                    state_d = ST_IDLE;
                    click_d = 1'b1;
                end
            end
            ST_P2: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    dbl_d   = 1'b1;
                end else if (timer_q == LONG_LAST) begin
                    // The first short press is confirmed as a click at the
                    // moment the second one turns into a long hold.
                    state_d = ST_LONG;
                    click_d = 1'b1;
                    long_d  = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (timer_q == REPEAT_LAST) begin
                    rpt_d     = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state entry restarts the timer
        if (state_d != state_q) begin
            timer_clr = 1'b1;
        end
    end

    // Saturating timer next value
    always_comb begin
        if (timer_clr) begin
            timer_d = '0;
        end else if (timer_q == TIMER_MAX) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TIMER_ONE;
        end
    end

    // State, timer and registered event outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            // Track the live level during reset so a button held across
            // reset release is not mistaken for a fresh press.
            prev_q    <= btn_level;
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dbl_q     <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            prev_q    <= btn_level;
            state_q   <= state_d;
            timer_q   <= timer_d;
            held_q    <= btn_level;
            press_q   <= rise;
            release_q <= fall;
            click_q   <= click_d;
            dbl_q     <= dbl_d;
            long_q    <= long_d;
            rpt_q     <= rpt_d;
        end
    end

    // Output mapping
    always_comb begin
        held        = held_q;
        press       = press_q;
        btn_release = release_q;
        click       = click_q;
        dbl_click   = dbl_q;
        long_press  = long_q;
        auto_repeat = rpt_q;
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder with LONG=8, DBL=6, REPEAT=4.
// Each scenario pushes its expected events (absolute cycle, event vector) into
// a scoreboard queue before driving; every cycle the outputs are compared to
// the queue head when it is due, otherwise to "no event".

module tb_button_event_decoder;

    localparam logic [5:0] E_PRS = 6'b100000;
    localparam logic [5:0] E_REL = 6'b010000;
    localparam logic [5:0] E_CLK = 6'b001000;
    localparam logic [5:0] E_DBL = 6'b000100;
    localparam logic [5:0] E_LNG = 6'b000010;
    localparam logic [5:0] E_RPT = 6'b000001;

    typedef struct {
        int unsigned cyc;
        logic [5:0]  ev;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_level = 1'b0;
    logic held, press, btn_release, click, dbl_click, long_press, auto_repeat;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int unsigned base = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic        held_exp = 1'b0;

    button_event_decoder #(
        .LONG_CYCLES  (8),
        .DBL_CYCLES   (6),
        .REPEAT_CYCLES(4),
        .CTR_WIDTH    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_level  (btn_level),
        .held       (held),
        .press      (press),
        .btn_release(btn_release),
        .click      (click),
        .dbl_click  (dbl_click),
        .long_press (long_press),
        .auto_repeat(auto_repeat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Expected event at scenario-relative cycle off
    task automatic expect_ev(input int unsigned off, input logic [5:0] ev);
        exp_t e;
        e.cyc = base + off;
        e.ev  = ev;
        sb_q.push_back(e);
    endtask

    // One clock: apply inputs, sample #1 after the edge, compare
    task automatic step(input logic lvl, input logic r);
        logic [5:0] exp_ev;
        exp_t       e;
        btn_level = lvl;
        rst       = r;
        held_exp  = r ? 1'b0 : lvl;
        @(posedge clk);
        #1;
        exp_ev = '0;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e      = sb_q.pop_front();
            exp_ev = e.ev;
        end
        check("events", {26'd0, press, btn_release, click, dbl_click, long_press, auto_repeat},
              {26'd0, exp_ev});
        check("held", {31'd0, held}, {31'd0, held_exp});
        cyc++;
    endtask

    task automatic drive(input logic lvl, input int unsigned n);
        for (int i = 0; i < int'(n); i++) step(lvl, 1'b0);
    endtask

    initial begin
        // Reset: all outputs must stay low
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        drive(1'b0, 3);

        // Single click: held 3, idle 10
        base = cyc;
        expect_ev(0, E_PRS);
        expect_ev(3, E_REL);
        expect_ev(9, E_CLK);
        drive(1'b1, 3);
        drive(1'b0, 10);

        // Double click: held 3, gap 2, held 3
        base = cyc;
        expect_ev(0, E_PRS);
        expect_ev(3, E_REL);
        expect_ev(5, E_PRS);
        expect_ev(8, E_REL | E_DBL);
        drive(1'b1, 3);
        drive(1'b0, 2);
        drive(1'b1, 3);
        drive(1'b0, 10);

        // Long hold of 20; the fall coincides with a repeat threshold and wins
        base = cyc;
        expect_ev(0, E_PRS);
        expect_ev(8, E_LNG);
        expect_ev(12, E_RPT);
        expect_ev(16, E_RPT);
        expect_ev(20, E_REL);
        drive(1'b1, 20);
        drive(1'b0, 10);

        // Second rise exactly at the last W2 cycle: no click, goes to P2
        base = cyc;
        expect_ev(0, E_PRS);
        expect_ev(1, E_REL);
        expect_ev(7, E_PRS);
        expect_ev(9, E_REL | E_DBL);
        drive(1'b1, 1);
        drive(1'b0, 6);
        drive(1'b1, 2);
        drive(1'b0, 10);

        // Second press held long: click and long_press together, then repeat
        base = cyc;
        expect_ev(0, E_PRS);
        expect_ev(1, E_REL);
        expect_ev(2, E_PRS);
        expect_ev(10, E_CLK | E_LNG);
        expect_ev(14, E_RPT);
        expect_ev(15, E_REL);
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 13);
        drive(1'b0, 10);

        // Button held through reset release: no press/click, only the release
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
        base = cyc;
        expect_ev(5, E_REL);
        drive(1'b1, 5);
        drive(1'b0, 10);

        // Reset while in W2 aborts the pending click; next press is fresh
        base = cyc;
        expect_ev(0, E_PRS);
        expect_ev(1, E_REL);
        expect_ev(9, E_PRS);
        expect_ev(10, E_REL);
        expect_ev(16, E_CLK);
        drive(1'b1, 1);
        drive(1'b0, 1);
        step(1'b0, 1'b1);
        drive(1'b0, 6);
        drive(1'b1, 1);
        drive(1'b0, 10);

        // Long idle: timer saturation in IDLE must not produce events
        drive(1'b0, 40);

        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
